// File: rtl/axi_txn_ctrl_pkg.sv
// Shared types and defaults for the single-outstanding AXI-Lite transaction
// sequencer.
//   state_e      : controller FSM states
//   *_DEF        : default bus widths and watchdog limit
//   wdog_width() : bits needed to hold the watchdog limit (minimum 1)
package axi_txn_ctrl_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_AR   = 3'd1,
        ST_RD_R    = 3'd2,
        ST_WR_AW_W = 3'd3,
        ST_WR_B    = 3'd4
    } state_e;

    function automatic int wdog_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_txn_ctrl_if.sv
// AXI-Lite style five-channel bundle between the transaction sequencer
// (master) and the addressed slave.
//   AR : arvalid/arready/ar_addr     R : rvalid/rready/r_data
//   AW : awvalid/awready/aw_addr     W : wvalid/wready/w_data
//   B  : bvalid/bready
interface axi_txn_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] ar_addr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] r_data;
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] aw_addr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] w_data;
    logic              bvalid;
    logic              bready;

    modport master (
        output arvalid, ar_addr, rready, awvalid, aw_addr, wvalid, w_data, bready,
        input  arready, rvalid, r_data, awready, wready, bvalid
    );

    modport slave (
        input  arvalid, ar_addr, rready, awvalid, aw_addr, wvalid, w_data, bready,
        output arready, rvalid, r_data, awready, wready, bvalid
    );
endinterface

// File: rtl/axi_wdog_cnt.sv
// Per-phase watchdog for the transaction sequencer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : restart the count (new phase entered)
//   tick_i       : one more cycle spent waiting for the phase handshake
//   limit_i      : wait budget in cycles; 0 disables expiry
//   expired_o    : combinational, high on the tick that uses up the budget
module axi_wdog_cnt #(
    parameter int CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count stops at the limit so it can never wrap back into range.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count starts at 0 on phase entry, so a phase is abandoned after
    // exactly limit_i waiting cycles. A handshake suppresses the tick, so it
    // always beats expiry in the same cycle.
    assign expired_o = tick_i && (limit_i != '0) && ((cnt_q + ONE) == limit_i);

endmodule

// File: rtl/axi_txn_ctrl.sv
// Single-outstanding AXI-Lite transaction sequencer: takes one command,
// runs the read (AR then R) or write (AW+W then B) channel sequence on the
// slave, and returns one rsp_valid pulse. A per-phase watchdog aborts a
// stalled slave with rsp_err.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o : command handshake (ready only while idle)
//   cmd_we_i, cmd_addr_i, cmd_wdata_i : command payload
//   rsp_valid_o, rsp_rdata_o, rsp_err_o : completion pulse and result
//   axi                     : master side of the five AXI-Lite channels
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_RD_AR   | arvalid high, waiting for arready
// ST_RD_R    | rready high, waiting for rvalid
// ST_WR_AW_W | awvalid/wvalid high until each one's own handshake
// ST_WR_B    | bready high, waiting for bvalid
module axi_txn_ctrl
    import axi_txn_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    axi_txn_ctrl_if.master    axi
);
    localparam int               CNT_W    = wdog_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYC);

    state_e state_q, state_d;

    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_both;
    logic done, timeout;
    logic wd_tick, wd_clear, wd_expired;

    assign accept  = cmd_valid_i & cmd_ready_q;
    assign ar_hs   = arvalid_q & axi.arready;
    assign r_hs    = rready_q & axi.rvalid;
    assign aw_hs   = awvalid_q & axi.awready;
    assign w_hs    = wvalid_q & axi.wready;
    assign b_hs    = bready_q & axi.bvalid;
    assign wr_both = (aw_done_q | aw_hs) & (w_done_q | w_hs);

    // Kept apart from the next-state block so the watchdog expiry feeding
    // back into state_d is not seen as a combinational loop.
    always_comb begin
        wd_tick = 1'b0;
        case (state_q)
            ST_RD_AR:   wd_tick = !ar_hs;
            ST_RD_R:    wd_tick = !r_hs;
            ST_WR_AW_W: wd_tick = !wr_both;
            ST_WR_B:    wd_tick = !b_hs;
            default:    wd_tick = 1'b0;
        endcase
    end

    // Every state change is an entry into a fresh phase.
    assign wd_clear = (state_d != state_q);

    axi_wdog_cnt #(
        .CNT_W (CNT_W)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wd_clear),
        .tick_i    (wd_tick),
        .limit_i   (WD_LIMIT),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done      = 1'b0;
        timeout   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = cmd_we_i ? ST_WR_AW_W : ST_RD_AR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_RD_AR: begin
                if (ar_hs) begin
                    state_d = ST_RD_R;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_RD_R: begin
                if (r_hs) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_WR_AW_W: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (wr_both) begin
                    state_d = ST_WR_B;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_WR_B: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All outputs are registered, so their next values follow state_d.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        arvalid_d   = (state_d == ST_RD_AR);
        rready_d    = (state_d == ST_RD_R);
        awvalid_d   = (state_d == ST_WR_AW_W) && !aw_done_d;
        wvalid_d    = (state_d == ST_WR_AW_W) && !w_done_d;
        bready_d    = (state_d == ST_WR_B);
        rsp_valid_d = done | timeout;
        rsp_err_d   = timeout;
        rsp_rdata_d = (state_q == ST_RD_R && r_hs) ? axi.r_data : '0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if (accept) begin
            addr_d  = cmd_addr_i;
            wdata_d = cmd_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign axi.arvalid = arvalid_q;
    assign axi.ar_addr = addr_q;
    assign axi.rready  = rready_q;
    assign axi.awvalid = awvalid_q;
    assign axi.aw_addr = addr_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.w_data  = wdata_q;
    assign axi.bready  = bready_q;

endmodule
